// File: rtl/add_sub_pkg.sv
// add_sub_pkg
//   Shared types and elaboration-time helpers for the serial adder/subtractor.
//   - state_e      : controller states (IDLE, CALC, DONE)
//   - n_slices     : number of DIGIT-bit slices in a WIDTH-bit operand
//   - idx_width    : width of the slice index counter, ceil(log2(N+1))
//   - geometry_ok  : legal WIDTH/DIGIT combination (WIDTH a multiple of DIGIT)
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int n_slices(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int idx_width(input int n_sl);
    return (n_sl < 1) ? 1 : $clog2(n_sl + 1);
  endfunction

  function automatic bit geometry_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/add_sub_digit.sv
// add_sub_digit
//   Purely combinational DIGIT-bit ripple-carry slice.
//   Ports:
//     a_d   in  DIGIT  operand A slice
//     b_d   in  DIGIT  operand B slice, already inverted for subtraction
//     cin   in  1      carry into bit 0
//     s_d   out DIGIT  slice sum
//     cout  out 1      carry out of the top bit
//     c_msb out 1      carry into the top bit (feeds signed overflow)
module add_sub_digit
  import add_sub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign s_d[gi]   = a_d[gi] ^ b_d[gi] ^ c[gi];
    assign c[gi + 1] = (a_d[gi] & b_d[gi]) | (c[gi] & (a_d[gi] ^ b_d[gi]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/add_sub_serial.sv
// add_sub_serial
//   Multi-cycle WIDTH-bit adder/subtractor that reuses one DIGIT-bit ripple
//   slice, one slice per clock, with valid/ready handshakes on both sides.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//     a, b, sub            operands and mode (0 = A+B, 1 = A-B)
//     out_valid / out_ready result handshake (out_valid high only in DONE)
//     s, cout, ovf, zero   result and flags, all registered
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = n_slices(WIDTH, DIGIT);
  localparam int IDX_W = idx_width(N);

  if (!geometry_ok(WIDTH, DIGIT)) begin : g_bad_geometry
    $error("add_sub_serial: WIDTH must be a positive multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;     // B already XORed with sub
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [DIGIT-1:0]   a_dig, b_dig, s_dig;
  logic               dig_cout, dig_c_msb;

  // Select the active slice of each operand register.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = op_a_q[i*DIGIT +: DIGIT];
        b_dig = op_b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (a_dig),
    .b_d   (b_dig),
    .cin   (carry_q),
    .s_d   (s_dig),
    .cout  (dig_cout),
    .c_msb (dig_c_msb)
  );

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_a_d     = a;
          // Subtraction is A + ~B + 1: invert B here and seed carry with sub.
          op_b_d     = b ^ {WIDTH{sub}};
          carry_d    = sub;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            s_d[i*DIGIT +: DIGIT] = s_dig;
          end
        end
        carry_d = dig_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          // Last slice: its carries are the MSB carries of the whole word.
          cout_d      = dig_cout;
          ovf_d       = dig_c_msb ^ dig_cout;
          zero_d      = (s_d == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Testbench for add_sub_serial: three instances (DIGIT = 4, 1, 16) at WIDTH=16
// share operand/reset/out_ready inputs; in_valid is steered to one instance.
module tb_add_sub_serial;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in, b_in;
  logic        sub_in;
  logic        out_ready;
  logic        in_valid_v [3];
  logic        in_ready_m [3];
  logic        out_valid_m[3];
  logic [15:0] s_m        [3];
  logic        cout_m     [3];
  logic        ovf_m      [3];
  logic        zero_m     [3];

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int cyc    = 0;
  int lat_of [3] = '{4, 16, 1};
  res_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_sub_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_m[0]),
    .a(a_in), .b(b_in), .sub(sub_in), .out_valid(out_valid_m[0]), .out_ready(out_ready),
    .s(s_m[0]), .cout(cout_m[0]), .ovf(ovf_m[0]), .zero(zero_m[0]));

  add_sub_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_m[1]),
    .a(a_in), .b(b_in), .sub(sub_in), .out_valid(out_valid_m[1]), .out_ready(out_ready),
    .s(s_m[1]), .cout(cout_m[1]), .ovf(ovf_m[1]), .zero(zero_m[1]));

  add_sub_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_m[2]),
    .a(a_in), .b(b_in), .sub(sub_in), .out_valid(out_valid_m[2]), .out_ready(out_ready),
    .s(s_m[2]), .cout(cout_m[2]), .ovf(ovf_m[2]), .zero(zero_m[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d actual=%h required=%h", name, sel, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic m);
    res_t r;
    logic [16:0] f;
    logic [15:0] yy;
    yy  = m ? ~y : y;
    f   = {1'b0, x} + {1'b0, yy} + {16'd0, m};
    r.s = f[15:0];
    r.c = f[16];
    if (m) r.v = (x[15] != y[15]) && (r.s[15] != x[15]);
    else   r.v = (x[15] == y[15]) && (r.s[15] != x[15]);
    r.z = (r.s == 16'd0);
    return r;
  endfunction

  task automatic compare_out(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard dut=%0d actual=empty required=entry", tag, sel);
    end else begin
      e = sb.pop_front();
      chk({tag, "_s"},    {16'd0, s_m[sel]},  {16'd0, e.s});
      chk({tag, "_cout"}, {31'd0, cout_m[sel]}, {31'd0, e.c});
      chk({tag, "_ovf"},  {31'd0, ovf_m[sel]},  {31'd0, e.v});
      chk({tag, "_zero"}, {31'd0, zero_m[sel]}, {31'd0, e.z});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_m[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready_m[sel]}, 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_m[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input logic ss,
                        input res_t e, input string tag);
    int n;
    out_ready = 1'b1;
    wait_ready();
    a_in = aa; b_in = bb; sub_in = ss;
    in_valid_v[sel] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid_v[sel] = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready_m[sel]}, 32'd0);
    wait_valid(n);
    chk({tag, "_latency"}, n, lat_of[sel]);
    $display("txn dut=%0d a=%h b=%h sub=%0d s=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             sel, aa, bb, ss, s_m[sel], cout_m[sel], ovf_m[sel], zero_m[sel], n);
    compare_out(tag);
    @(negedge clk);
    chk({tag, "_ov_drop"}, {31'd0, out_valid_m[sel]}, 32'd0);
    chk({tag, "_ir_rise"}, {31'd0, in_ready_m[sel]}, 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid_m[sel]}, 32'd0);
    chk({tag, "_s"},         {16'd0, s_m[sel]}, 32'd0);
    chk({tag, "_flags"},     {29'd0, cout_m[sel], ovf_m[sel], zero_m[sel]}, 32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready_m[sel]}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int n, acc0, acc1;
    logic seen_ov;
    logic [15:0] ra, rb;
    logic rs;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    vecs[4] = '{16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};

    rst = 1'b1; a_in = '0; b_in = '0; sub_in = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      chk_reset_state("reset");
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on all three geometries.
    for (int d = 0; d < 3; d++) begin
      sel = d;
      for (int i = 0; i < 6; i++)
        run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: result held in DONE, new operands ignored.
    sel = 0;
    out_ready = 1'b0;
    wait_ready();
    a_in = 16'h1234; b_in = 16'h1111; sub_in = 1'b0;
    in_valid_v[0] = 1'b1;
    sb.push_back(vecs[0].exp);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    wait_valid(n);
    chk("bp_latency", n, 4);
    for (int k = 0; k < 10; k++) begin
      a_in = 16'hAAAA + 16'(k); b_in = 16'h5555; sub_in = k[0];
      in_valid_v[0] = 1'b1;
      @(negedge clk);
      chk("bp_hold_s", {16'd0, s_m[0]}, 32'h2345);
      chk("bp_hold_valid", {31'd0, out_valid_m[0]}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, in_ready_m[0]}, 32'd0);
    end
    in_valid_v[0] = 1'b0;
    $display("txn dut=0 backpressure s=%h held 10 cycles", s_m[0]);
    compare_out("bp");
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready_m[0]}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid_m[0]}, 32'd0);

    // Back-to-back issue spacing with in_valid held high.
    a_in = 16'h0100; b_in = 16'h0023; sub_in = 1'b0;
    in_valid_v[0] = 1'b1;
    acc0 = cyc;
    sb.push_back(model(16'h0100, 16'h0023, 1'b0));
    n = 0;
    @(negedge clk);
    while (!in_ready_m[0] && n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid_m[0]) compare_out("spacing_first");
    end
    acc1 = cyc;
    chk("issue_spacing", acc1 - acc0, 6);
    sb.push_back(model(16'h0100, 16'h0023, 1'b0));
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    wait_valid(n);
    $display("txn dut=0 spacing=%0d s=%h", acc1 - acc0, s_m[0]);
    compare_out("spacing_second");
    @(negedge clk);

    // Reset after two CALC slices: nothing emerges, no residue.
    wait_ready();
    a_in = 16'hFFFF; b_in = 16'hFFFF; sub_in = 1'b0;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midcalc_reset");
    rst = 1'b0;
    seen_ov = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_ov = seen_ov | out_valid_m[0];
    end
    chk("midcalc_no_output", {31'd0, seen_ov}, 32'd0);
    $display("txn dut=0 reset mid-CALC, aborted op discarded");
    run_op(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0}, "post_reset");

    // Random operands and modes across all geometries.
    for (int i = 0; i < 1000; i++) begin
      sel = i % 3;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) rb = ra;
      run_op(ra, rb, rs, model(ra, rb, rs), "rand");
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
